// File: rtl/cpu6502_interrupt_sequencer_if.sv
// Pin, boundary and sequencing signals shared between the 6502 core FSM and
// the interrupt sequencer. The core side (master) drives the pins and the
// instruction-boundary qualifiers and follows the step/vector outputs.
interface cpu6502_interrupt_sequencer_if;
   logic        enable;
   logic        interrupt_N;
   logic        nonMaskableInterrupt_N;
   logic        reset_N;
   logic        interruptDisableFlag;
   logic        instructionBoundary;
   logic        brkRequest;

   logic        takeover;
   logic [2:0]  step;
   logic [15:0] vectorAddress;
   logic        stackWriteInhibit;
   logic        pushBreakFlag;
   logic        setInterruptDisable;

   modport master (
      output enable,
      output interrupt_N,
      output nonMaskableInterrupt_N,
      output reset_N,
      output interruptDisableFlag,
      output instructionBoundary,
      output brkRequest,
      input  takeover,
      input  step,
      input  vectorAddress,
      input  stackWriteInhibit,
      input  pushBreakFlag,
      input  setInterruptDisable
   );

   modport slave (
      input  enable,
      input  interrupt_N,
      input  nonMaskableInterrupt_N,
      input  reset_N,
      input  interruptDisableFlag,
      input  instructionBoundary,
      input  brkRequest,
      output takeover,
      output step,
      output vectorAddress,
      output stackWriteInhibit,
      output pushBreakFlag,
      output setInterruptDisable
   );
endinterface

// File: rtl/cpu6502_interrupt_sequencer.sv
// 6502 interrupt / BRK / RESET entry sequencer.
// Samples the IRQ, NMI and RESET pins, picks a winner at an instruction
// boundary (RESET > NMI > IRQ > BRK) and walks the core through the 7-cycle
// entry sequence: two dummy cycles, three stack pushes, two vector fetches.
// While takeover is high the core FSM follows step instead of the opcode.
module cpu6502_interrupt_sequencer #(
   parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
   parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
   parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
   input  logic                                clock,
   input  logic                                reset,
   cpu6502_interrupt_sequencer_if.slave        bus
);

   typedef enum logic [2:0] {
      STEP_IDLE      = 3'd0,
      STEP_DUMMY_A   = 3'd1,
      STEP_DUMMY_B   = 3'd2,
      STEP_PUSH_PCH  = 3'd3,
      STEP_PUSH_PCL  = 3'd4,
      STEP_PUSH_P    = 3'd5,
      STEP_VECTOR_LO = 3'd6,
      STEP_VECTOR_HI = 3'd7
   } stepType;

   typedef enum logic [1:0] {
      SOURCE_RESET = 2'd0,
      SOURCE_NMI   = 2'd1,
      SOURCE_IRQ   = 2'd2,
      SOURCE_BRK   = 2'd3
   } sourceType;

   stepType     state;
   stepType     nextState;
   sourceType   source;
   sourceType   nextSource;
   logic        fromBrk;
   logic        nextFromBrk;
   logic        nmiPrev;
   logic        nmiPending;
   logic        nextNmiPending;
   logic        resetPending;
   logic        nextResetPending;

   logic        nmiEdge;
   logic        irqActive;
   logic        hijackWindow;
   logic [15:0] nextVectorBase;

   logic        takeoverReg;
   logic [15:0] vectorReg;
   logic        inhibitReg;
   logic        pushBreakReg;

   // Pin qualifiers: NMI edge against the last enabled sample, IRQ as a live
   // level masked by P.I, and the window in which an NMI may steal a sequence.
   always_comb begin
      nmiEdge      = nmiPrev && !bus.nonMaskableInterrupt_N;
      irqActive    = !bus.interrupt_N && !bus.interruptDisableFlag;
      hijackWindow = (state == STEP_DUMMY_A) || (state == STEP_DUMMY_B) ||
                     (state == STEP_PUSH_PCH) || (state == STEP_PUSH_PCL);
   end

   // Next-state logic: arbitration at the boundary, the fixed step walk,
   // NMI hijack of IRQ/BRK, and the pending-flag bookkeeping. A low RESET pin
   // throws away any partial sequence and re-arms the RESET entry. An NMI edge
   // always wins over the step-5 clear so a late edge is never lost.
   always_comb begin
      nextState        = state;
      nextSource       = source;
      nextFromBrk      = fromBrk;
      nextNmiPending   = nmiPending;
      nextResetPending = resetPending;
      if (bus.enable) begin
         if (!bus.reset_N) begin
            nextState        = STEP_IDLE;
            nextResetPending = 1'b1;
         end else begin
            case (state)
               STEP_IDLE: begin
                  if (bus.instructionBoundary) begin
                     if (resetPending) begin
                        nextState   = STEP_DUMMY_A;
                        nextSource  = SOURCE_RESET;
                        nextFromBrk = 1'b0;
                     end else if (nmiPending) begin
                        nextState   = STEP_DUMMY_A;
                        nextSource  = SOURCE_NMI;
                        nextFromBrk = 1'b0;
                     end else if (irqActive) begin
                        nextState   = STEP_DUMMY_A;
                        nextSource  = SOURCE_IRQ;
                        nextFromBrk = 1'b0;
                     end else if (bus.brkRequest) begin
                        nextState   = STEP_DUMMY_A;
                        nextSource  = SOURCE_BRK;
                        nextFromBrk = 1'b1;
                     end
                  end
               end
               STEP_DUMMY_A:   nextState = STEP_DUMMY_B;
               STEP_DUMMY_B:   nextState = STEP_PUSH_PCH;
               STEP_PUSH_PCH:  nextState = STEP_PUSH_PCL;
               STEP_PUSH_PCL:  nextState = STEP_PUSH_P;
               STEP_PUSH_P: begin
                  nextState = STEP_VECTOR_LO;
                  if (source == SOURCE_NMI) begin
                     nextNmiPending = 1'b0;
                  end
               end
               STEP_VECTOR_LO: nextState = STEP_VECTOR_HI;
               STEP_VECTOR_HI: begin
                  nextState = STEP_IDLE;
                  if (source == SOURCE_RESET) begin
                     nextResetPending = 1'b0;
                  end
               end
               default:        nextState = STEP_IDLE;
            endcase
            if (nmiEdge && hijackWindow &&
                ((source == SOURCE_IRQ) || (source == SOURCE_BRK))) begin
               nextSource = SOURCE_NMI;
            end
         end
         if (nmiEdge) begin
            nextNmiPending = 1'b1;
         end
      end
   end

   // Vector base for the source that will be current after this edge; BRK
   // shares the IRQ vector.
   always_comb begin
      case (nextSource)
         SOURCE_RESET: nextVectorBase = RESET_VECTOR;
         SOURCE_NMI:   nextVectorBase = NMI_VECTOR;
         default:      nextVectorBase = IRQ_VECTOR;
      endcase
   end

   // State and output registers. Outputs are decoded from the next state so
   // they line up with the registered step in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= STEP_IDLE;
         source       <= SOURCE_RESET;
         fromBrk      <= 1'b0;
         nmiPrev      <= 1'b1;
         nmiPending   <= 1'b0;
         resetPending <= 1'b1;
         takeoverReg  <= 1'b0;
         vectorReg    <= 16'h0000;
         inhibitReg   <= 1'b0;
         pushBreakReg <= 1'b0;
      end else begin
         state        <= nextState;
         source       <= nextSource;
         fromBrk      <= nextFromBrk;
         nmiPending   <= nextNmiPending;
         resetPending <= nextResetPending;
         if (bus.enable) begin
            nmiPrev <= bus.nonMaskableInterrupt_N;
         end
         takeoverReg  <= (nextState != STEP_IDLE);
         if (nextState == STEP_VECTOR_LO) begin
            vectorReg <= nextVectorBase;
         end else if (nextState == STEP_VECTOR_HI) begin
            vectorReg <= nextVectorBase + 16'd1;
         end else begin
            vectorReg <= 16'h0000;
         end
         inhibitReg   <= (nextSource == SOURCE_RESET) &&
                         ((nextState == STEP_PUSH_PCH) ||
                          (nextState == STEP_PUSH_PCL) ||
                          (nextState == STEP_PUSH_P));
         pushBreakReg <= (nextState == STEP_PUSH_P) && nextFromBrk;
      end
   end

   // The I-flag set is qualified by enable so it fires exactly once, in the
   // cycle where step 7 actually completes, even when enable stretches step 7.
   assign bus.setInterruptDisable = (state == STEP_VECTOR_HI) && bus.enable && !reset;
   assign bus.takeover            = takeoverReg;
   assign bus.step                = state;
   assign bus.vectorAddress       = vectorReg;
   assign bus.stackWriteInhibit   = inhibitReg;
   assign bus.pushBreakFlag       = pushBreakReg;

endmodule

// File: tb/tb_cpu6502_interrupt_sequencer.sv
// Self-checking bench for the 6502 interrupt sequencer. Each slot drives the
// inputs at the falling edge, pushes the expected outputs for that slot onto
// a scoreboard queue, and pops/compares them just after.
module tb_cpu6502_interrupt_sequencer;

   logic clock = 1'b0;
   logic reset;

   cpu6502_interrupt_sequencer_if bus();

   cpu6502_interrupt_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   typedef struct packed {
      logic        takeover;
      logic [2:0]  step;
      logic [15:0] vector;
      logic        inhibit;
      logic        pushB;
      logic        setI;
   } obsType;

   obsType expQ[$];
   int     checks = 0;
   int     errors = 0;

   // Expected outputs for a given step of a sequence.
   function automatic obsType model(int s, logic [15:0] base, bit isReset, bit isBrk, bit en);
      obsType r;
      r.takeover = (s != 0);
      r.step     = 3'(s);
      r.vector   = (s == 6) ? base : ((s == 7) ? base + 16'd1 : 16'h0000);
      r.inhibit  = isReset && (s >= 3) && (s <= 5);
      r.pushB    = isBrk && (s == 5);
      r.setI     = (s == 7) && en;
      return r;
   endfunction

   function automatic obsType observe();
      obsType r;
      r.takeover = bus.takeover;
      r.step     = bus.step;
      r.vector   = bus.vectorAddress;
      r.inhibit  = bus.stackWriteInhibit;
      r.pushB    = bus.pushBreakFlag;
      r.setI     = bus.setInterruptDisable;
      return r;
   endfunction

   task automatic quietInputs();
      bus.enable                 = 1'b1;
      bus.interrupt_N            = 1'b1;
      bus.nonMaskableInterrupt_N = 1'b1;
      bus.reset_N                = 1'b1;
      bus.interruptDisableFlag   = 1'b0;
      bus.instructionBoundary    = 1'b0;
      bus.brkRequest             = 1'b0;
   endtask

   task automatic test_reset();
      obsType got, exp;
      reset = 1'b1;
      quietInputs();
      @(negedge clock);
      expQ.push_back(model(0, 16'h0000, 0, 0, 1));
      #1;
      got = observe(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL reset got %h want %h", got, exp);
      end
      reset = 1'b0;
      @(negedge clock);
      expQ.push_back(model(0, 16'h0000, 0, 0, 1));
      #1;
      got = observe(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL resetIdle got %h want %h", got, exp);
      end
   endtask

   task automatic test_reset_entry();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         bus.instructionBoundary = (k == 0);
         expQ.push_back(model(s, 16'hFFFC, 1, 0, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL resetEntry slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_irq_over_brk();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         bus.instructionBoundary  = (k == 0);
         bus.brkRequest           = (k == 0);
         bus.interrupt_N          = (k != 0);
         bus.interruptDisableFlag = 1'b0;
         expQ.push_back(model(s, 16'hFFFE, 0, 0, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL irqOverBrk slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_brk_masked();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         bus.instructionBoundary  = (k == 0);
         bus.brkRequest           = (k == 0);
         bus.interrupt_N          = 1'b0;
         bus.interruptDisableFlag = 1'b1;
         expQ.push_back(model(s, 16'hFFFE, 0, 1, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL brkMasked slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_nmi_hijack();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clock);
         bus.instructionBoundary = (k == 0) || (k == 9);
         bus.brkRequest          = (k == 0);
         if (s == 3) bus.nonMaskableInterrupt_N = 1'b0;
         if (k == 9) bus.nonMaskableInterrupt_N = 1'b1;
         expQ.push_back(model(s, 16'hFFFA, 0, 1, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL nmiHijack slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_nmi_held();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         bus.nonMaskableInterrupt_N = 1'b0;
         bus.instructionBoundary    = (k == 1) || (k == 10);
         expQ.push_back(model(s, 16'hFFFA, 0, 0, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL nmiHeld slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 1) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_nmi_late();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 19; k++) begin
         @(negedge clock);
         bus.instructionBoundary = (k == 0) || (k == 9);
         bus.interrupt_N         = (k != 0);
         if (s == 6 && k < 9) bus.nonMaskableInterrupt_N = 1'b0;
         expQ.push_back(model(s, (k > 9) ? 16'hFFFA : 16'hFFFE, 0, 0, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL nmiLate slot %0d got %h want %h", k, got, exp);
         end
         if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0 || k == 9) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_reset_pin_abort();
      obsType got, exp;
      int s = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         bus.instructionBoundary = (k == 0) || (k == 4) || (k == 5);
         bus.interrupt_N         = (k != 0);
         bus.reset_N             = !((k == 3) || (k == 4));
         expQ.push_back(model(s, 16'hFFFC, (k > 5), 0, 1));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL resetPinAbort slot %0d got %h want %h", k, got, exp);
         end
         if (k == 3) s = 0;
         else if (s != 0) s = (s == 7) ? 0 : s + 1;
         else if (k == 0 || k == 5) s = 1;
      end
      quietInputs();
   endtask

   task automatic test_enable_toggle();
      obsType got, exp;
      int s = 0;
      bit en;
      for (int k = 0; k < 16; k++) begin
         @(negedge clock);
         en = ((k % 2) == 0);
         bus.enable              = en;
         bus.instructionBoundary = (k == 0);
         bus.interrupt_N         = (k != 0);
         expQ.push_back(model(s, 16'hFFFE, 0, 0, en));
         #1;
         got = observe(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL enableToggle slot %0d got %h want %h", k, got, exp);
         end
         if (en) begin
            if (s != 0) s = (s == 7) ? 0 : s + 1;
            else if (k == 0) s = 1;
         end
      end
      quietInputs();
   endtask

   // Scenario sequence; each task leaves the inputs quiet and the DUT idle.
   initial begin
      test_reset();
      test_reset_entry();
      test_irq_over_brk();
      test_brk_masked();
      test_nmi_hijack();
      test_nmi_held();
      test_nmi_late();
      test_reset_pin_abort();
      test_enable_toggle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
